egr_rrq_arb: RTL

Parametrised read-request concentrator between N word-read requestors (CPB, PRC, TDB, ...) and the single mesh read interface (MRI) request port.
- Each channel has its own request FIFO.
- Arbitration is class-aware round-robin: VCT requests are served before SAF requests.
- The source channel index is stamped into req_id.client_id.
- Output goes through a registered valid/ack stage.
- Generalises the fixed per-requestor valid/ack bundle to N channels, configurable depth and request width, with backpressure and occupancy visibility.

---
 rtl/egr_rrq_arb.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/egr_rrq_arb.sv
// egr_rrq_arb: N-channel word-read request concentrator onto the MRI request port; VCT-over-SAF round-robin; SAF anti-starvation under EGR_RRQ_ARB_STARVE_EN.
// Latency: request accepted in cycle t reaches mri_rreq_valid in t+2 at the earliest (FIFO then output register); 1 request/cycle.
// Backpressure: mri_rreq_ack low holds the output register stable; a full channel FIFO drops wd_rreq_ack for that channel.

module egr_rrq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          cclk,
  input  logic          rst,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_vld,
  output logic [W-1:0]  head_dat,
  output logic [AW:0]   occ
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge cclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_vld, pop_vld})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge cclk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end
endmodule

module egr_rrq_arb #(
  parameter int N_RREQS     = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int W_RREQ      = 41,
  parameter int W_CLIENT_ID = 3,
  parameter int STARVE_LIM  = 8,
  localparam int W_CHAN     = (N_RREQS > 1) ? $clog2(N_RREQS) : 1,
  localparam int W_OCC      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       cclk,
  input  logic                       rst,
  input  logic [N_RREQS*W_RREQ-1:0]  wd_rreq,
  input  logic [N_RREQS-1:0]         wd_rreq_valid,
  output logic [N_RREQS-1:0]         wd_rreq_ack,
  output logic [W_RREQ-1:0]          mri_rreq,
  output logic                       mri_rreq_valid,
  input  logic                       mri_rreq_ack,
  output logic [W_CHAN-1:0]          mri_rreq_chan,
  output logic [N_RREQS*W_OCC-1:0]   fifo_occ,
  output logic                       ovf_err
);
  localparam int CID_LSB  = 12;
  localparam int SC_BIT   = 1;
  localparam int HOLD_LIM = 1024;
  localparam int W_HOLD   = 11;

  logic [N_RREQS-1:0][W_RREQ-1:0] head_dat;
  logic [N_RREQS-1:0][W_OCC-1:0]  occ;
  logic [N_RREQS-1:0] push_vld;
  logic [N_RREQS-1:0] pop_vld;
  logic [N_RREQS-1:0] ne;
  logic [N_RREQS-1:0] is_vct;
  logic [N_RREQS-1:0] is_saf;
  logic [N_RREQS-1:0] hold_ovf;
  logic [N_RREQS-1:0] cand;
  logic               free;
  logic               any_vct;
  logic               any_saf;
  logic               use_vct;
  logic               force_saf;
  logic               gnt_vld;
  logic [W_CHAN-1:0]  vct_ptr;
  logic [W_CHAN-1:0]  saf_ptr;
  logic [W_CHAN-1:0]  ptr_sel;
  logic [W_CHAN-1:0]  idx;
  logic [W_CHAN-1:0]  gnt;
  logic [W_CHAN-1:0]  gnt_nxt;

  assign free     = ~mri_rreq_valid | mri_rreq_ack;
  assign fifo_occ = occ;

  for (genvar i = 0; i < N_RREQS; i++) begin : g_chan
    logic [W_RREQ-1:0] stamped;
    logic [W_HOLD-1:0] hold_cnt;
    logic              stalled;

    always_comb begin
      stamped = wd_rreq[i*W_RREQ +: W_RREQ];
      stamped[CID_LSB +: W_CLIENT_ID] = W_CLIENT_ID'(i);
    end

    // No bypass: a full FIFO refuses even when its head is popped this cycle.
    assign wd_rreq_ack[i] = wd_rreq_valid[i] & (occ[i] != W_OCC'(FIFO_DEPTH)) & ~rst;
    assign push_vld[i]    = wd_rreq_ack[i];
    assign pop_vld[i]     = free & gnt_vld & (gnt == W_CHAN'(i));
    assign ne[i]          = (occ[i] != '0);
    assign is_vct[i]      = ne[i] & head_dat[i][SC_BIT];
    assign is_saf[i]      = ne[i] & ~head_dat[i][SC_BIT];
    assign stalled        = wd_rreq_valid[i] & ~wd_rreq_ack[i];
    assign hold_ovf[i]    = stalled & (hold_cnt >= W_HOLD'(HOLD_LIM));

    always_ff @(posedge cclk) begin
      if (rst || !stalled) begin
        hold_cnt <= '0;
      end else if (hold_cnt != '1) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end

    egr_rrq_fifo #(
      .W     (W_RREQ),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .cclk     (cclk),
      .rst      (rst),
      .push_vld (push_vld[i]),
      .push_dat (stamped),
      .pop_vld  (pop_vld[i]),
      .head_dat (head_dat[i]),
      .occ      (occ[i])
    );
  end

`ifdef EGR_RRQ_ARB_STARVE_EN
  localparam int W_STARVE = $clog2(STARVE_LIM + 1);
  logic [W_STARVE-1:0] starve_cnt;

  assign force_saf = any_saf & (starve_cnt >= W_STARVE'(STARVE_LIM));

  // Counts back-to-back VCT grants only while some SAF head is actually waiting.
  always_ff @(posedge cclk) begin
    if (rst || !any_saf) begin
      starve_cnt <= '0;
    end else if (free && gnt_vld) begin
      if (use_vct) starve_cnt <= starve_cnt + 1'b1;
      else         starve_cnt <= '0;
    end
  end
`else
  // Strict VCT priority; the limit only matters with the anti-starvation counter.
  assign force_saf = (STARVE_LIM < 0);
`endif

  always_comb begin
    any_vct = |is_vct;
    any_saf = |is_saf;
    use_vct = any_vct & ~force_saf;
    cand    = use_vct ? is_vct : is_saf;
    ptr_sel = use_vct ? vct_ptr : saf_ptr;
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    // Scan downwards so the candidate closest to the class pointer wins.
    for (int k = N_RREQS - 1; k >= 0; k--) begin
      idx = W_CHAN'((int'(ptr_sel) + k) % N_RREQS);
      if (cand[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
    gnt_nxt = (gnt == W_CHAN'(N_RREQS - 1)) ? '0 : gnt + 1'b1;
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      mri_rreq       <= '0;
      mri_rreq_valid <= 1'b0;
      mri_rreq_chan  <= '0;
      vct_ptr        <= '0;
      saf_ptr        <= '0;
      ovf_err        <= 1'b0;
    end else begin
      ovf_err <= ovf_err | (|hold_ovf);
      if (free) begin
        mri_rreq_valid <= gnt_vld;
        if (gnt_vld) begin
          mri_rreq      <= head_dat[gnt];
          mri_rreq_chan <= gnt;
          if (use_vct) vct_ptr <= gnt_nxt;
          else         saf_ptr <= gnt_nxt;
        end
      end
    end
  end
endmodule
